temp_to_digits: RTL

Converts a raw DS18B20-format temperature word (16-bit two's complement, 1/16 °C per LSB) into six 4-bit display digits plus a per-digit valid mask, ready to drive `seg_disp` `din`/`din_vld` directly. The block takes the sign and absolute value, scales the fraction to two decimal digits, and converts with an iterative double-dabble, one shift per clock. It sits between the sensor read-out controller and `seg_disp`.

---
 rtl/temp_to_digits_pkg.sv | 23 ++
 rtl/temp_to_digits_if.sv | 21 ++
 rtl/temp_to_digits_bcd_add3.sv | 9 +
 rtl/temp_to_digits.sv | 117 +++++++++++
 4 files changed

// File: rtl/temp_to_digits_pkg.sv
// Shared constants and types for the temperature-to-display-digit converter.
// The digit constants are also what seg_disp is built against.
package temp_to_digits_pkg;

    localparam int         MAX_SMG_NUM = 6;
    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] NEG_CODE    = 4'hF;
    localparam logic [3:0] POS_CODE    = 4'h0;

    localparam int RAW_W   = 16;
    localparam int VAL_W   = 15;
    localparam int BCD_W   = 20;
    localparam int DOUT_W  = MAX_SMG_NUM * DIGIT_W;
    localparam int SHIFT_N = VAL_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/temp_to_digits_if.sv
// Request/result bundle between the sensor read-out side and the digit converter.
interface temp_to_digits_if;
    import temp_to_digits_pkg::*;

    logic [RAW_W-1:0]       temp_in;
    logic                   temp_vld;
    logic                   busy;
    logic [DOUT_W-1:0]      dout;
    logic [MAX_SMG_NUM-1:0] dout_vld;

    modport master (
        output temp_in, temp_vld,
        input  busy, dout, dout_vld
    );

    modport slave (
        input  temp_in, temp_vld,
        output busy, dout, dout_vld
    );

endinterface

// File: rtl/temp_to_digits_bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/temp_to_digits.sv
// Converts a DS18B20 temperature word into sign + five BCD digits with a change mask,
// using a one-bit-per-clock double-dabble.
module temp_to_digits
    import temp_to_digits_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    temp_to_digits_if.slave  tif
);

    localparam logic [3:0] LAST_ITER = 4'(SHIFT_N - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    first_q, first_d;
    logic [DOUT_W-1:0]       dout_q, dout_d;
    logic [MAX_SMG_NUM-1:0]  vld_q, vld_d;

    logic signed [RAW_W-1:0] raw_q;
    logic                    neg_q;
    logic [VAL_W-1:0]        val_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [BCD_W-1:0]        bcd_adj;

    // Fraction in 1/16 degC scaled to hundredths, truncating: (f * 25) >> 2.
    function automatic logic [6:0] frac_to_cents(input logic [3:0] frac);
        logic [8:0] prod;
        prod = 9'(frac) * 9'd25;
        return prod[8:2];
    endfunction

    // Magnitude in hundredths of a degree; raw 16'h8000 wraps to an integer part of 0.
    function automatic logic [VAL_W-1:0] scaled_value(input logic signed [RAW_W-1:0] raw);
        logic [RAW_W-1:0] mag;
        mag = raw[RAW_W-1] ? RAW_W'(-raw) : RAW_W'(raw);
        return VAL_W'(8'(mag >> 4)) * VAL_W'(100) + VAL_W'(frac_to_cents(4'(mag)));
    endfunction

    for (genvar i = 0; i < BCD_W / DIGIT_W; i++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i (bcd_q[i*DIGIT_W +: DIGIT_W]),
            .d_o (bcd_adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        dout_d  = dout_q;
        vld_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (tif.temp_vld) state_d = ST_PREP;
            end
            ST_PREP: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) state_d = ST_DONE;
            end
            ST_DONE: begin
                dout_d = {neg_q ? NEG_CODE : POS_CODE, bcd_q};
                for (int i = 0; i < MAX_SMG_NUM; i++) begin
                    vld_d[i] = dout_d[i*DIGIT_W +: DIGIT_W] != dout_q[i*DIGIT_W +: DIGIT_W];
                end
                // The display starts blank, so the first result after reset lights every digit.
                if (first_q) vld_d = '1;
                first_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            first_q <= 1'b1;
            dout_q  <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    // Datapath registers carry no reset; every conversion reloads them before use.
    always_ff @(posedge clk) begin
        case (state_q)
            ST_IDLE: begin
                if (tif.temp_vld) raw_q <= tif.temp_in;
            end
            ST_PREP: begin
                neg_q <= raw_q[RAW_W-1];
                val_q <= scaled_value(raw_q);
                bcd_q <= '0;
            end
            ST_SHIFT: begin
                bcd_q <= {bcd_adj[BCD_W-2:0], val_q[VAL_W-1]};
                val_q <= {val_q[VAL_W-2:0], 1'b0};
            end
            default: ;
        endcase
    end

    assign tif.busy     = (state_q != ST_IDLE);
    assign tif.dout     = dout_q;
    assign tif.dout_vld = vld_q;

endmodule
